// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV64 pipeline.
// Resolves DMEM handshakes, MUL/DIV occupancy, branch redirects, load-use and fetch stalls.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_is_mdu,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             mem_dmem_valid,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_DONE
  } dmem_state_t;

  localparam int MDU_CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [MDU_CW-1:0] MDU_LAST = MDU_CW'(MDU_LAT - 1);

  dmem_state_t       state_q;
  dmem_state_t       state_d;
  logic [MDU_CW-1:0] mdu_cnt;
  logic              mdu_done;
  logic              mem_stall;
  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= DMEM_IDLE;
    else      state_q <= state_d;
  end

  // DONE is the single cycle in which the MEM instruction is allowed to move on.
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (mem_dmem_valid) begin
          dmem_req = 1'b1;
          state_d  = DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) state_d = DMEM_DONE;
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
    if (!rst) dmem_req = 1'b0;
  end

  assign mem_stall = mem_dmem_valid && (state_q != DMEM_DONE);
  assign mdu_busy  = rst && ex_is_mdu && !mdu_done;
  assign rs1_hit   = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit   = id_rs2_used && (id_rs2 == ex_rd);
  assign load_use  = ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mdu_busy) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
    end else if (!imem_ready) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
    end
    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_en    = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  // The count keeps running under a MEM stall; done is held until EX actually advances.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mdu_cnt  <= '0;
      mdu_done <= 1'b0;
    end else if (mdu_busy) begin
      if (mdu_cnt == MDU_LAST) begin
        mdu_cnt  <= '0;
        mdu_done <= 1'b1;
      end else begin
        mdu_cnt <= mdu_cnt + MDU_CW'(1);
      end
    end else if (mdu_done && ex_is_mdu && ex_mem_en) begin
      mdu_done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)        stall_cnt <= '0;
    else if (!pc_en) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl, checked against a cycle model.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 8;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs1;
    logic       id_rs1_used;
    logic [4:0] id_rs2;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_is_load;
    logic       ex_is_mdu;
    logic       ex_redirect;
    logic       imem_ready;
    logic       mem_dmem_valid;
    logic       dmem_ready;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_is_mdu, ex_redirect;
  logic        imem_ready, mem_dmem_valid, dmem_ready;
  logic        dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mdu_busy;
  logic [31:0] stall_cnt;

  int tests = 0;
  int failures = 0;

  // Model state: outstanding request, completion cycle, MDU progress, stall total.
  bit          m_in_access = 1'b0;
  bit          m_done_cycle = 1'b0;
  int          m_elapsed = 0;
  bit          m_finished = 1'b0;
  logic [31:0] m_stalls = '0;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_mdu(ex_is_mdu),
    .ex_redirect(ex_redirect), .imem_ready(imem_ready),
    .mem_dmem_valid(mem_dmem_valid), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    s.imem_ready = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; id_rs1 = s.id_rs1; id_rs1_used = s.id_rs1_used;
    id_rs2 = s.id_rs2; id_rs2_used = s.id_rs2_used; ex_rd = s.ex_rd;
    ex_is_load = s.ex_is_load; ex_is_mdu = s.ex_is_mdu; ex_redirect = s.ex_redirect;
    imem_ready = s.imem_ready; mem_dmem_valid = s.mem_dmem_valid; dmem_ready = s.dmem_ready;
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic applyStimulus(input stim_t s, input string tag);
    bit e_req, e_pc, e_ifen, e_iffl, e_iden, e_idfl, e_exen, e_exfl, e_wben, e_wbfl, e_busy;
    bit stall_mem, hazard;
    @(negedge clk);
    drive(s);
    #1;
    e_busy    = s.rst && s.ex_is_mdu && !m_finished;
    stall_mem = s.mem_dmem_valid && !m_done_cycle;
    e_req     = s.rst && (m_in_access || (s.mem_dmem_valid && !m_done_cycle));
    hazard    = s.ex_is_load && s.ex_rd != 0 &&
                ((s.id_rs1_used && s.id_rs1 == s.ex_rd) || (s.id_rs2_used && s.id_rs2 == s.ex_rd));
    {e_pc, e_ifen, e_iden, e_exen, e_wben} = 5'b11111;
    {e_iffl, e_idfl, e_exfl, e_wbfl} = 4'b0000;
    if (stall_mem) begin
      {e_pc, e_ifen, e_iden, e_exen} = 4'b0000; e_wbfl = 1'b1;
    end else if (e_busy) begin
      {e_pc, e_ifen, e_iden} = 3'b000; e_exfl = 1'b1;
    end else if (s.ex_redirect) begin
      e_iffl = 1'b1; e_idfl = 1'b1;
    end else if (hazard) begin
      e_pc = 1'b0; e_ifen = 1'b0; e_idfl = 1'b1;
    end else if (!s.imem_ready) begin
      e_pc = 1'b0; e_iffl = 1'b1;
    end
    if (!s.rst) begin
      {e_pc, e_ifen, e_iffl, e_iden, e_idfl, e_exen, e_exfl, e_wben, e_wbfl} = '0;
    end
    checkOutput({tag, " ctrl"},
      {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
       ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, mdu_busy},
      {e_req, e_pc, e_ifen, e_iffl, e_iden, e_idfl, e_exen, e_exfl, e_wben, e_wbfl, e_busy});
    checkOutput({tag, " stall_cnt"}, stall_cnt, m_stalls);
    if (!s.rst) begin
      m_in_access = 0; m_done_cycle = 0; m_elapsed = 0; m_finished = 0; m_stalls = '0;
    end else begin
      if (!e_pc) m_stalls = m_stalls + 1;
      if (m_done_cycle) m_done_cycle = 0;
      else if (m_in_access) begin
        if (s.dmem_ready) begin m_in_access = 0; m_done_cycle = 1; end
      end else if (s.mem_dmem_valid) m_in_access = 1;
      if (e_busy) begin
        m_elapsed++;
        if (m_elapsed == MDU_LAT) begin m_elapsed = 0; m_finished = 1; end
      end else if (m_finished && s.ex_is_mdu && e_exen) m_finished = 0;
    end
  endtask

  task automatic runMdu(input string tag);
    stim_t s;
    int busy_cycles;
    s = idleStim();
    s.ex_is_mdu = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < MDU_LAT + 1; i++) begin
      applyStimulus(s, tag);
      if (mdu_busy === 1'b1) busy_cycles++;
    end
    checkOutput({tag, " busy_cycles"}, busy_cycles, MDU_LAT);
    applyStimulus(idleStim(), tag);
  endtask

  initial begin
    stim_t s;
    logic [31:0] s0;
    s = idleStim();
    s.rst = 1'b0;
    drive(s);
    applyStimulus(s, "reset");
    applyStimulus(s, "reset");
    applyStimulus(idleStim(), "idle");

    // Load-use hit on rs2, then the same with ex_rd=0, then rs1 match but unused.
    s = idleStim();
    s0 = stall_cnt;
    s.ex_is_load = 1; s.ex_rd = 5; s.id_rs2 = 5; s.id_rs2_used = 1;
    applyStimulus(s, "load_use");
    applyStimulus(idleStim(), "load_use_after");
    checkOutput("load_use stall_delta", stall_cnt - s0, 1);
    s.ex_rd = 0; s.id_rs2 = 0;
    s0 = stall_cnt;
    applyStimulus(s, "load_use_x0");
    s = idleStim();
    s.ex_is_load = 1; s.ex_rd = 7; s.id_rs1 = 7; s.id_rs1_used = 0;
    applyStimulus(s, "rs1_unused");
    applyStimulus(idleStim(), "rs1_unused_after");
    checkOutput("no_stall stall_delta", stall_cnt - s0, 0);

    // DMEM access with ready on the fourth WAIT cycle.
    applyStimulus(idleStim(), "dmem_pre");
    s0 = stall_cnt;
    s = idleStim();
    s.mem_dmem_valid = 1;
    for (int i = 0; i < 5; i++) begin
      s.dmem_ready = (i == 4);
      applyStimulus(s, "dmem_wait");
    end
    s.dmem_ready = 0;
    applyStimulus(s, "dmem_done");
    checkOutput("dmem_done pc_en", pc_en, 1);
    applyStimulus(idleStim(), "dmem_post");
    checkOutput("dmem stall_delta", stall_cnt - s0, 5);

    runMdu("mdu");

    // Redirect beats load-use and fetch stall; redirect under a MEM stall waits for DONE.
    s = idleStim();
    s.ex_redirect = 1; s.ex_is_load = 1; s.ex_rd = 3; s.id_rs1 = 3; s.id_rs1_used = 1;
    s.imem_ready = 0;
    applyStimulus(s, "redirect_combo");
    s = idleStim();
    s.ex_redirect = 1; s.mem_dmem_valid = 1;
    applyStimulus(s, "redirect_memstall");
    s.dmem_ready = 1;
    applyStimulus(s, "redirect_memstall");
    s.dmem_ready = 0;
    applyStimulus(s, "redirect_done");
    checkOutput("redirect_done if_id_flush", if_id_flush, 1);
    applyStimulus(idleStim(), "idle");

    // Reset while in WAIT with a partial MDU count.
    s = idleStim();
    s.mem_dmem_valid = 1; s.ex_is_mdu = 1;
    for (int i = 0; i < 3; i++) applyStimulus(s, "pre_reset");
    s.rst = 0;
    applyStimulus(s, "mid_reset");
    applyStimulus(idleStim(), "post_reset");
    checkOutput("post_reset stall_cnt", stall_cnt, 0);
    checkOutput("post_reset dmem_req", dmem_req, 0);
    runMdu("mdu_after_reset");

    s = idleStim();
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(199) != 0);
      if ($urandom_range(11) == 0) s.ex_is_mdu = ~s.ex_is_mdu;
      if ($urandom_range(5) == 0) s.mem_dmem_valid = ~s.mem_dmem_valid;
      s.dmem_ready = ($urandom_range(2) == 0);
      s.imem_ready = ($urandom_range(7) != 0);
      s.ex_redirect = ($urandom_range(7) == 0);
      s.ex_is_load = ($urandom_range(2) == 0);
      s.ex_rd = 5'($urandom_range(3));
      s.id_rs1 = 5'($urandom_range(3));
      s.id_rs2 = 5'($urandom_range(3));
      s.id_rs1_used = 1'($urandom_range(1));
      s.id_rs2_used = 1'($urandom_range(1));
      applyStimulus(s, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
